// File: rtl/spi_apb_regif_pkg.sv
// Shared widths, register map, FSM state and request types for the SPI APB
// register front end.
package SPI_package;

  localparam int unsigned SPI_DEF_DATA_WIDTH  = 32;
  localparam int unsigned SPI_DEF_PADDR_WIDTH = 5;
  localparam int unsigned SPI_MAX_DATA_WIDTH  = 64;
  localparam int unsigned SPI_MAX_STRB_WIDTH  = SPI_MAX_DATA_WIDTH / 8;
  localparam int unsigned SPI_IDX_WIDTH       = 3;

  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_CR     = 3'd0;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_BR     = 3'd1;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_INTER  = 3'd2;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_SR     = 3'd3;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_RINTR  = 3'd4;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_INTR   = 3'd5;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_TXDATA = 3'd6;
  localparam logic [SPI_IDX_WIDTH-1:0] SPI_IDX_RXDATA = 3'd7;

  typedef enum logic [1:0] {
    SPI_ST_IDLE   = 2'd0,
    SPI_ST_ACCESS = 2'd1,
    SPI_ST_WAIT   = 2'd2,
    SPI_ST_RESP   = 2'd3
  } spi_apb_state_e;

  // Data/strobe fields are sized for the widest supported bus.
  typedef struct packed {
    logic                          write;
    logic [SPI_IDX_WIDTH-1:0]      idx;
    logic [SPI_MAX_DATA_WIDTH-1:0] data;
    logic [SPI_MAX_STRB_WIDTH-1:0] strb;
    logic                          err;
  } spi_apb_req_t;

endpackage

// File: rtl/spi_apb_regif_bytereg.sv
// Single byte-strobed read/write register with a parameterised reset value.
module spi_apb_bytereg
  import SPI_package::*;
#(
  parameter int unsigned           WIDTH     = SPI_DEF_DATA_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [WIDTH-1:0]     d,
  output logic [WIDTH-1:0]     q
);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int unsigned i = 0; i < WIDTH / 8; i++) begin
        if (be[i]) q[8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_apb_regif.sv
// APB slave front end for the SPI core: RW control registers, RO status,
// TX push / RX pop with wait states. Optional feature macro: SPI_APB_WAIT_EN.
module spi_apb_regif
  import SPI_package::*;
#(
  parameter int unsigned SPI_DATA_WIDTH  = 32,
  parameter int unsigned SPI_PADDR_WIDTH = 5,
  parameter int unsigned STRB_WIDTH      = SPI_DATA_WIDTH / 8,
  parameter int unsigned WAIT_TIMEOUT    = 16,
  parameter logic [SPI_DATA_WIDTH-1:0] CR_RESET    = '0,
  parameter logic [SPI_DATA_WIDTH-1:0] BR_RESET    = '0,
  parameter logic [SPI_DATA_WIDTH-1:0] INTER_RESET = '0
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [SPI_PADDR_WIDTH-1:0] paddr,
  input  logic [SPI_DATA_WIDTH-1:0]  pwdata,
  input  logic [STRB_WIDTH-1:0]      pstrb,
  output logic [SPI_DATA_WIDTH-1:0]  prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [SPI_DATA_WIDTH-1:0]  cr_q,
  output logic [SPI_DATA_WIDTH-1:0]  br_q,
  output logic [SPI_DATA_WIDTH-1:0]  inter_q,
  input  logic [SPI_DATA_WIDTH-1:0]  sr_in,
  input  logic [SPI_DATA_WIDTH-1:0]  rintr_in,
  input  logic [SPI_DATA_WIDTH-1:0]  intr_in,
  output logic                       tfifo_wen,
  output logic [SPI_DATA_WIDTH-1:0]  tfifo_wdata,
  input  logic                       tfifo_full,
  output logic                       rfifo_ren,
  input  logic [SPI_DATA_WIDTH-1:0]  rfifo_rdata,
  input  logic                       rfifo_empty
);

  // Only paddr[4:2] may be set; alignment and high bits are errors.
  localparam logic [SPI_PADDR_WIDTH-1:0] ADDR_IDX_MASK = SPI_PADDR_WIDTH'(5'b11100);

  spi_apb_state_e            state, state_nxt;
  spi_apb_req_t              req;
  logic [SPI_IDX_WIDTH-1:0]  setup_idx;
  logic                      setup_err, fifo_block, resp_err, enter_resp, reg_we;
  logic [SPI_DATA_WIDTH-1:0] rd_mux;
  logic                      unused_req_bits;

  assign setup_idx       = paddr[4:2];
  assign unused_req_bits = ^{req.data, req.strb};

  always_comb begin
    setup_err = |(paddr & ~ADDR_IDX_MASK);
    if (pwrite) begin
      if (setup_idx inside {SPI_IDX_SR, SPI_IDX_RINTR, SPI_IDX_INTR, SPI_IDX_RXDATA}) setup_err = 1'b1;
      if (setup_idx == SPI_IDX_TXDATA && pstrb != '1) setup_err = 1'b1;
    end else if (setup_idx == SPI_IDX_TXDATA) begin
      setup_err = 1'b1;
    end
  end

  assign fifo_block = req.write ? (req.idx == SPI_IDX_TXDATA && tfifo_full)
                                : (req.idx == SPI_IDX_RXDATA && rfifo_empty);

`ifdef SPI_APB_WAIT_EN
  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unsigned unused_wait_timeout = WAIT_TIMEOUT;
`endif

  always_comb begin
    state_nxt = state;
    resp_err  = req.err;
    case (state)
      SPI_ST_IDLE:   if (psel && !penable) state_nxt = SPI_ST_ACCESS;
      SPI_ST_ACCESS: begin
        state_nxt = SPI_ST_RESP;
        if (!req.err && fifo_block) begin
`ifdef SPI_APB_WAIT_EN
          state_nxt = SPI_ST_WAIT;
`else
          resp_err = 1'b1;
`endif
        end
      end
`ifdef SPI_APB_WAIT_EN
      // FIFO release wins over a timeout reached in the same cycle.
      SPI_ST_WAIT: begin
        if (!fifo_block) begin
          state_nxt = SPI_ST_RESP;
        end else if (wait_cnt == CNT_W'(WAIT_TIMEOUT)) begin
          state_nxt = SPI_ST_RESP;
          resp_err  = 1'b1;
        end
      end
`endif
      SPI_ST_RESP:   state_nxt = SPI_ST_IDLE;
      default:       state_nxt = SPI_ST_IDLE;
    endcase
  end

  assign enter_resp = (state != SPI_ST_RESP) && (state_nxt == SPI_ST_RESP);

  always_comb begin
    rd_mux = '0;
    case (req.idx)
      SPI_IDX_CR:     rd_mux = cr_q;
      SPI_IDX_BR:     rd_mux = br_q;
      SPI_IDX_INTER:  rd_mux = inter_q;
      SPI_IDX_SR:     rd_mux = sr_in;
      SPI_IDX_RINTR:  rd_mux = rintr_in;
      SPI_IDX_INTR:   rd_mux = intr_in;
      SPI_IDX_RXDATA: rd_mux = rfifo_rdata;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state     <= SPI_ST_IDLE;
      req       <= '0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      tfifo_wen <= 1'b0;
      rfifo_ren <= 1'b0;
    end else begin
      state     <= state_nxt;
      pready    <= enter_resp;
      pslverr   <= enter_resp && resp_err;
      tfifo_wen <= enter_resp && !resp_err && req.write && req.idx == SPI_IDX_TXDATA;
      rfifo_ren <= enter_resp && !resp_err && !req.write && req.idx == SPI_IDX_RXDATA;
      if (state == SPI_ST_IDLE && psel && !penable) begin
        req.write <= pwrite;
        req.idx   <= setup_idx;
        req.data  <= SPI_MAX_DATA_WIDTH'(pwdata);
        req.strb  <= SPI_MAX_STRB_WIDTH'(pstrb);
        req.err   <= setup_err;
      end
      if (enter_resp) prdata <= (resp_err || req.write) ? '0 : rd_mux;
    end
  end

`ifdef SPI_APB_WAIT_EN
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wait_cnt <= '0;
    end else if (state == SPI_ST_ACCESS && state_nxt == SPI_ST_WAIT) begin
      wait_cnt <= CNT_W'(1);
    end else if (state == SPI_ST_WAIT && state_nxt == SPI_ST_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`endif

  assign tfifo_wdata = req.data[SPI_DATA_WIDTH-1:0];
  assign reg_we      = (state == SPI_ST_RESP) && !pslverr && req.write;

  spi_apb_bytereg #(.WIDTH(SPI_DATA_WIDTH), .RESET_VAL(CR_RESET)) u_cr (
    .pclk(pclk), .preset_n(preset_n), .we(reg_we && req.idx == SPI_IDX_CR),
    .be(req.strb[STRB_WIDTH-1:0]), .d(req.data[SPI_DATA_WIDTH-1:0]), .q(cr_q)
  );

  spi_apb_bytereg #(.WIDTH(SPI_DATA_WIDTH), .RESET_VAL(BR_RESET)) u_br (
    .pclk(pclk), .preset_n(preset_n), .we(reg_we && req.idx == SPI_IDX_BR),
    .be(req.strb[STRB_WIDTH-1:0]), .d(req.data[SPI_DATA_WIDTH-1:0]), .q(br_q)
  );

  spi_apb_bytereg #(.WIDTH(SPI_DATA_WIDTH), .RESET_VAL(INTER_RESET)) u_inter (
    .pclk(pclk), .preset_n(preset_n), .we(reg_we && req.idx == SPI_IDX_INTER),
    .be(req.strb[STRB_WIDTH-1:0]), .d(req.data[SPI_DATA_WIDTH-1:0]), .q(inter_q)
  );

endmodule

// File: tb/tb_spi_apb_regif.sv
// Self-checking bench for spi_apb_regif against a transaction-level reference
// model; follows SPI_APB_WAIT_EN the same way as the design.
module tb_spi_apb_regif;

  localparam int unsigned TO = 4;
  localparam logic [31:0] CR_RST    = 32'h0000_00A5;
  localparam logic [31:0] BR_RST    = 32'h0000_0000;
  localparam logic [31:0] INTER_RST = 32'hC3C3_0F0F;

  logic        pclk = 1'b0;
  logic        preset_n, psel, penable, pwrite;
  logic [6:0]  paddr;
  logic [31:0] pwdata, prdata, cr_q, br_q, inter_q, sr_in, rintr_in, intr_in;
  logic [31:0] tfifo_wdata, rfifo_rdata;
  logic [3:0]  pstrb;
  logic        pready, pslverr, tfifo_wen, tfifo_full, rfifo_ren, rfifo_empty;

  int compared = 0;
  int mismatched = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] m_reg [3];

  spi_apb_regif #(
    .SPI_DATA_WIDTH(32), .SPI_PADDR_WIDTH(7), .STRB_WIDTH(4), .WAIT_TIMEOUT(TO),
    .CR_RESET(CR_RST), .BR_RESET(BR_RST), .INTER_RESET(INTER_RST)
  ) dut (
    .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .cr_q(cr_q), .br_q(br_q), .inter_q(inter_q), .sr_in(sr_in),
    .rintr_in(rintr_in), .intr_in(intr_in), .tfifo_wen(tfifo_wen), .tfifo_wdata(tfifo_wdata),
    .tfifo_full(tfifo_full), .rfifo_ren(rfifo_ren), .rfifo_rdata(rfifo_rdata),
    .rfifo_empty(rfifo_empty)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (tfifo_wen) begin wen_cnt++; last_wdata = tfifo_wdata; end
    if (rfifo_ren) ren_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_reg[0] = CR_RST; m_reg[1] = BR_RST; m_reg[2] = INTER_RST;
  endtask

  // Expected outcome of one transfer, from the register map and error rules.
  task automatic model_xfer(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input logic full, input logic empty, input int rel_n,
                            output logic [31:0] e_rd, output logic e_er, output int e_cyc,
                            output int e_wen, output int e_ren);
    int idx;
    logic blocked;
    idx = int'(addr[4:2]);
    e_er = (addr[1:0] != 0) || (addr[6:5] != 0) || (wr && idx inside {3, 4, 5, 7}) ||
           (!wr && idx == 6) || (wr && idx == 6 && st != 4'hF);
    blocked = !e_er && ((wr && idx == 6 && full) || (!wr && idx == 7 && empty));
    e_cyc = 1;
    if (blocked) begin
`ifdef SPI_APB_WAIT_EN
      if (rel_n >= 1 && rel_n <= int'(TO)) e_cyc = rel_n + 1;
      else begin e_cyc = int'(TO) + 1; e_er = 1'b1; end
`else
      e_er = 1'b1;
`endif
    end
    e_rd = '0; e_wen = 0; e_ren = 0;
    if (!e_er) begin
      if (wr) begin
        if (idx <= 2) begin
          for (int b = 0; b < 4; b++) if (st[b]) m_reg[idx][8*b +: 8] = wd[8*b +: 8];
        end else e_wen = 1;
      end else begin
        case (idx)
          0, 1, 2: e_rd = m_reg[idx];
          3: e_rd = sr_in;
          4: e_rd = rintr_in;
          5: e_rd = intr_in;
          7: begin e_rd = rfifo_rdata; e_ren = 1; end
          default: e_rd = '0;
        endcase
      end
    end
  endtask

  // Drives one APB transfer; FIFO flags clear at wait cycle rel_n (0 = never).
  task automatic apb_xfer(input logic wr, input logic [6:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input int rel_n,
                          output logic [31:0] rd, output logic er, output int cyc,
                          output int wens, output int rens, output logic [31:0] wdat);
    int wen0, ren0;
    wen0 = wen_cnt; ren0 = ren_cnt;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge pclk); #1;
    penable = 1;
    sr_in = $urandom; rintr_in = $urandom; intr_in = $urandom;
    cyc = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge pclk); #1;
      cyc++;
      if (pready) begin rd = prdata; er = pslverr; break; end
      if (cyc == rel_n) begin tfifo_full = 0; rfifo_empty = 0; end
    end
    psel = 0; penable = 0;
    @(posedge pclk); #1;
    wens = wen_cnt - wen0; rens = ren_cnt - ren0; wdat = last_wdata;
  endtask

  task automatic test_reset();
    preset_n = 0;
    repeat (2) @(posedge pclk);
    #1;
    model_reset();
    compared++; if (prdata !== 32'h0) begin mismatched++; $display("FAIL reset_prdata got=%h exp=0", prdata); end
    compared++; if ({pready, pslverr, tfifo_wen, rfifo_ren} !== 4'b0) begin mismatched++;
      $display("FAIL reset_ctrl got=%b exp=0000", {pready, pslverr, tfifo_wen, rfifo_ren}); end
    compared++; if ({cr_q, br_q, inter_q} !== {m_reg[0], m_reg[1], m_reg[2]}) begin mismatched++;
      $display("FAIL reset_regs got=%h/%h/%h exp=%h/%h/%h", cr_q, br_q, inter_q, m_reg[0], m_reg[1], m_reg[2]); end
    preset_n = 1;
    @(posedge pclk); #1;
  endtask

  task automatic test_cr_reset_read();
    logic [31:0] rd, wd; logic er; int cyc, w, r;
    apb_xfer(1'b0, 7'h00, 32'h0, 4'h0, 0, rd, er, cyc, w, r, wd);
    compared++; if (rd !== 32'h0000_00A5) begin mismatched++; $display("FAIL cr_read prdata got=%h exp=000000a5", rd); end
    compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL cr_read pslverr got=%b exp=0", er); end
    compared++; if (cyc != 1) begin mismatched++; $display("FAIL cr_read latency got=%0d exp=1", cyc); end
  endtask

  task automatic test_strobe_write();
    logic [31:0] rd, wd, e_rd; logic er, e_er; int cyc, w, r, e_cyc, e_w, e_r;
    apb_xfer(1'b1, 7'h04, 32'h1122_3344, 4'b0101, 0, rd, er, cyc, w, r, wd);
    model_xfer(1'b1, 7'h04, 32'h1122_3344, 4'b0101, 1'b0, 1'b0, 0, e_rd, e_er, e_cyc, e_w, e_r);
    compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL br_write pslverr got=%b exp=0", er); end
    compared++; if (br_q !== 32'h0022_0044) begin mismatched++; $display("FAIL br_q got=%h exp=00220044", br_q); end
    apb_xfer(1'b0, 7'h04, 32'h0, 4'h0, 0, rd, er, cyc, w, r, wd);
    compared++; if (rd !== 32'h0022_0044) begin mismatched++; $display("FAIL br_read got=%h exp=00220044", rd); end
  endtask

  task automatic test_tx_wait();
    logic [31:0] rd, wd, data, e_rd; logic er, e_er; int cyc, w, r, e_cyc, e_w, e_r;
    data = $urandom;
    tfifo_full = 1;
    apb_xfer(1'b1, 7'h18, data, 4'hF, 3, rd, er, cyc, w, r, wd);
    model_xfer(1'b1, 7'h18, data, 4'hF, 1'b1, 1'b0, 3, e_rd, e_er, e_cyc, e_w, e_r);
    tfifo_full = 0;
    compared++; if (cyc != e_cyc) begin mismatched++; $display("FAIL tx_wait latency got=%0d exp=%0d", cyc, e_cyc); end
    compared++; if (er !== e_er) begin mismatched++; $display("FAIL tx_wait pslverr got=%b exp=%b", er, e_er); end
    compared++; if (w != e_w) begin mismatched++; $display("FAIL tx_wait wen_pulses got=%0d exp=%0d", w, e_w); end
    if (e_w == 1) begin
      compared++; if (wd !== data) begin mismatched++; $display("FAIL tx_wait wdata got=%h exp=%h", wd, data); end
    end
  endtask

  task automatic test_rx_timeout();
    logic [31:0] rd, wd, e_rd; logic er, e_er; int cyc, w, r, e_cyc, e_w, e_r;
    rfifo_empty = 1; rfifo_rdata = $urandom;
    apb_xfer(1'b0, 7'h1C, 32'h0, 4'h0, 0, rd, er, cyc, w, r, wd);
    model_xfer(1'b0, 7'h1C, 32'h0, 4'h0, 1'b0, 1'b1, 0, e_rd, e_er, e_cyc, e_w, e_r);
    rfifo_empty = 0;
    compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL rx_timeout pslverr got=%b exp=1", er); end
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL rx_timeout prdata got=%h exp=0", rd); end
    compared++; if (r != 0) begin mismatched++; $display("FAIL rx_timeout ren_pulses got=%0d exp=0", r); end
    compared++; if (cyc != e_cyc) begin mismatched++; $display("FAIL rx_timeout latency got=%0d exp=%0d", cyc, e_cyc); end
  endtask

  task automatic test_ro_errors();
    logic [31:0] rd, wd; logic er; int cyc, w, r;
    apb_xfer(1'b1, 7'h0C, 32'hFFFF_FFFF, 4'hF, 0, rd, er, cyc, w, r, wd);
    compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL sr_write pslverr got=%b exp=1", er); end
    apb_xfer(1'b0, 7'h0C, 32'h0, 4'h0, 0, rd, er, cyc, w, r, wd);
    compared++; if (rd !== sr_in || er !== 1'b0) begin mismatched++;
      $display("FAIL sr_read got=%h/%b exp=%h/0", rd, er, sr_in); end
    apb_xfer(1'b1, 7'h05, 32'hDEAD_BEEF, 4'hF, 0, rd, er, cyc, w, r, wd);
    compared++; if (er !== 1'b1 || rd !== 32'h0) begin mismatched++;
      $display("FAIL misaligned_write got=%b/%h exp=1/00000000", er, rd); end
    compared++; if (cr_q !== m_reg[0]) begin mismatched++; $display("FAIL cr_unchanged got=%h exp=%h", cr_q, m_reg[0]); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, wd; logic er; int cyc, w, r, wen0;
    wen0 = wen_cnt;
    tfifo_full = 1;
    psel = 1; penable = 0; pwrite = 1; paddr = 7'h18; pwdata = $urandom; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1;
    repeat (2) @(posedge pclk);
    #1;
    preset_n = 0; psel = 0; penable = 0;
    @(posedge pclk); #1;
    model_reset();
    compared++; if ({prdata, pready, pslverr, tfifo_wen, rfifo_ren} !== 36'h0) begin mismatched++;
      $display("FAIL reset_wait outputs got=%h/%b%b%b%b exp=0", prdata, pready, pslverr, tfifo_wen, rfifo_ren); end
    compared++; if (br_q !== m_reg[1]) begin mismatched++; $display("FAIL reset_wait br_q got=%h exp=%h", br_q, m_reg[1]); end
    preset_n = 1; tfifo_full = 0;
    @(posedge pclk); #1;
    compared++; if (wen_cnt != wen0) begin mismatched++; $display("FAIL reset_wait wen_pulses got=%0d exp=0", wen_cnt - wen0); end
    apb_xfer(1'b0, 7'h00, 32'h0, 4'h0, 0, rd, er, cyc, w, r, wd);
    compared++; if (rd !== m_reg[0] || er !== 1'b0 || cyc != 1) begin mismatched++;
      $display("FAIL after_reset_read got=%h/%b/%0d exp=%h/0/1", rd, er, cyc, m_reg[0]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, data, e_rd; logic er, e_er, wr, f, e; logic [6:0] addr; logic [3:0] st;
    int cyc, w, r, e_cyc, e_w, e_r, rel;
    for (int n = 0; n < 80; n++) begin
      wr = 1'(($urandom_range(0, 1)));
      addr = ($urandom_range(0, 3) != 0) ? {2'b00, 3'($urandom_range(0, 7)), 2'b00} : 7'($urandom);
      st = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      data = $urandom; rfifo_rdata = $urandom;
      f = 1'($urandom_range(0, 1)); e = 1'($urandom_range(0, 1));
      rel = $urandom_range(0, TO + 1);
      tfifo_full = f; rfifo_empty = e;
      apb_xfer(wr, addr, data, st, rel, rd, er, cyc, w, r, wd);
      model_xfer(wr, addr, data, st, f, e, rel, e_rd, e_er, e_cyc, e_w, e_r);
      compared++; if (er !== e_er || cyc != e_cyc) begin mismatched++;
        $display("FAIL rand[%0d] err/lat got=%b/%0d exp=%b/%0d addr=%h wr=%b", n, er, cyc, e_er, e_cyc, addr, wr); end
      if (!wr || e_er) begin
        compared++; if (rd !== e_rd) begin mismatched++; $display("FAIL rand[%0d] prdata got=%h exp=%h", n, rd, e_rd); end
      end
      compared++; if (w != e_w || r != e_r) begin mismatched++;
        $display("FAIL rand[%0d] strobes got=%0d/%0d exp=%0d/%0d", n, w, r, e_w, e_r); end
      if (e_w == 1) begin
        compared++; if (wd !== data) begin mismatched++; $display("FAIL rand[%0d] wdata got=%h exp=%h", n, wd, data); end
      end
      compared++; if ({cr_q, br_q, inter_q} !== {m_reg[0], m_reg[1], m_reg[2]}) begin mismatched++;
        $display("FAIL rand[%0d] regs got=%h/%h/%h exp=%h/%h/%h", n, cr_q, br_q, inter_q, m_reg[0], m_reg[1], m_reg[2]); end
    end
    tfifo_full = 0; rfifo_empty = 0;
  endtask

  initial begin
    preset_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    sr_in = $urandom; rintr_in = $urandom; intr_in = $urandom;
    tfifo_full = 0; rfifo_empty = 0; rfifo_rdata = '0;
    model_reset();
    test_reset();
    test_cr_reset_read();
    test_strobe_write();
    test_tx_wait();
    test_rx_timeout();
    test_ro_errors();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
